// File: rtl/uart_stream_scheduler.sv
// Shares the FPGA->PC UART put channel among N clients (round-robin) and drains the PC->FPGA get channel into a valid/ready register.
// Latency: grant/put one cycle after a request is sampled in T_IDLE; rx_valid one cycle after rtr is sampled low in R_IDLE.
// Backpressure: no put while rts=1 or put_ack=1; no get while rx_data holds an unconsumed byte that is not being taken this cycle.
module uart_stream_scheduler #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rts,
    input  logic           rtr,
    input  logic [7:0]     byte_out,
    output logic           get,
    input  logic           get_ack,
    output logic [7:0]     byte_in,
    output logic           put,
    input  logic           put_ack,
    input  logic [N-1:0]   tx_req,
    input  logic [8*N-1:0] tx_data,
    output logic [N-1:0]   tx_grant,
    output logic [7:0]     rx_data,
    output logic           rx_valid,
    input  logic           rx_ready
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {T_IDLE, T_PUT, T_DROP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_GET, R_DROP} rx_state_t;

    tx_state_t       tx_state, tx_next;
    rx_state_t       rx_state, rx_next;
    logic [IW-1:0]   last;
    logic [IW-1:0]   winner;
    logic            win_vld;
    logic            tx_start;
    logic            rx_start;

    // Round-robin search: first requester after 'last'; scanning backwards lets the nearest one win.
    always_comb begin
        winner  = last;
        win_vld = 1'b0;
        for (int i = N; i >= 1; i--) begin
            if (tx_req[(int'(last) + i) % N]) begin
                winner  = IW'((int'(last) + i) % N);
                win_vld = 1'b1;
            end
        end
    end

    // A stale ack (e.g. left over across a reset) blocks the start of a new handshake.
    assign tx_start = (tx_state == T_IDLE) && win_vld && !rts && !put_ack;
    assign rx_start = (rx_state == R_IDLE) && !rtr && !get_ack && (!rx_valid || rx_ready);

    // State registers for both handshake FSMs.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= T_IDLE;
            rx_state <= R_IDLE;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
        end
    end

    // TX next state: four-phase put/put_ack sequence.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (tx_start) tx_next = T_PUT;
            T_PUT:   if (put_ack)  tx_next = T_DROP;
            T_DROP:  if (!put_ack) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    // RX next state: four-phase get/get_ack sequence.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_start) rx_next = R_GET;
            R_GET:   if (get_ack)  rx_next = R_DROP;
            R_DROP:  if (!get_ack) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // Handshake requests are pure state decodes, so they drop on the reset edge.
    always_comb begin
        put = (tx_state == T_PUT);
        get = (rx_state == R_GET);
    end

    // Datapath: grant pulse, byte capture toward the UART, pointer update, and the rx holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_in  <= 8'h00;
            tx_grant <= '0;
            last     <= IW'(N - 1);
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            tx_grant <= '0;
            if (tx_start) begin
                byte_in  <= tx_data[winner*8 +: 8];
                tx_grant <= {{(N-1){1'b0}}, 1'b1} << winner;
                last     <= winner;
            end
            if (rx_start) begin
                rx_data  <= byte_out;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_stream_scheduler.sv
// Bench for uart_stream_scheduler: arbitration table, directed handshake corners, and concurrent random traffic.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected bytes are queued when stimulus is driven and popped when the bytes emerge.
module tb_uart_stream_scheduler;

    localparam int N = 4;
    localparam int NBYTES = 1000;

    logic           clk = 1'b0;
    logic           reset;
    logic           rts, rtr;
    logic [7:0]     byte_out;
    logic           get, get_ack;
    logic [7:0]     byte_in;
    logic           put, put_ack;
    logic [N-1:0]   tx_req;
    logic [8*N-1:0] tx_data;
    logic [N-1:0]   tx_grant;
    logic [7:0]     rx_data;
    logic           rx_valid, rx_ready;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int tx_gr = 0;
    int tx_iss = 0;
    int tx_got = 0;
    int rx_got = 0;

    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] grant;
        logic [7:0]   data;
        int           ack_dly;
    } arb_vec_t;

    arb_vec_t tbl[12];

    uart_stream_scheduler #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .rts      (rts),
        .rtr      (rtr),
        .byte_out (byte_out),
        .get      (get),
        .get_ack  (get_ack),
        .byte_in  (byte_in),
        .put      (put),
        .put_ack  (put_ack),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .tx_grant (tx_grant),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete put handshake with a hand-timed UART ack.
    task automatic tx_xfer(input arb_vec_t v);
        tx_req = v.req;
        for (int c = 0; c < 20 && tx_grant == '0; c++) tick();
        chk("grant", 32'(tx_grant), 32'(v.grant));
        chk("byte_in", 32'(byte_in), 32'(v.data));
        chk("put_rise", 32'(put), 32'd1);
        tx_req = '0;
        tick();
        chk("grant_pulse", 32'(tx_grant), 32'd0);
        repeat (v.ack_dly) begin
            chk("put_hold", 32'(put), 32'd1);
            tick();
        end
        put_ack = 1'b1;
        tick();
        chk("put_fall", 32'(put), 32'd0);
        put_ack = 1'b0;
        tick();
    endtask

    // Random clients: present a byte, hold it until granted, queue it as expected at the grant.
    task automatic clients(input int lim);
        logic [N-1:0] rq;
        while (tx_gr < NBYTES && cyc < lim) begin
            tick();
            rq = tx_req;
            if (tx_grant != '0) begin
                chk("grant_valid", 32'({$onehot(tx_grant), |(tx_grant & ~rq)}), 32'b10);
                for (int i = 0; i < N; i++) begin
                    if (tx_grant[i]) begin
                        tx_exp.push_back(tx_data[i*8 +: 8]);
                        tx_req[i] = 1'b0;
                        tx_gr++;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!tx_req[i] && tx_iss < NBYTES && $urandom_range(0, 2) != 0) begin
                    tx_data[i*8 +: 8] = 8'($urandom);
                    tx_req[i] = 1'b1;
                    tx_iss++;
                end
            end
        end
        tx_req = '0;
    endtask

    // UART + PC model on the put side: ack after a random delay, hold rts until the PC reads.
    task automatic uart_tx(input int lim);
        logic [7:0] pend, e;
        while (tx_got < NBYTES && cyc < lim) begin
            tick();
            if (put) begin
                repeat ($urandom_range(0, 2)) tick();
                pend = byte_in;
                put_ack = 1'b1;
                rts = 1'b1;
                while (put && cyc < lim) tick();
                put_ack = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
                if (tx_exp.size() == 0) begin
                    chk("tx_extra", 32'(pend), 32'hFFFF_FFFF);
                end else begin
                    e = tx_exp.pop_front();
                    chk("tx_byte", 32'(pend), 32'(e));
                end
                tx_got++;
                rts = 1'b0;
            end
        end
    endtask

    // PC model on the get side: write a byte, ack the get, clear rtr as the byte is consumed.
    task automatic pc_rx(input int lim);
        logic [7:0] b;
        for (int k = 0; k < NBYTES && cyc < lim; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            b = 8'($urandom);
            rx_exp.push_back(b);
            byte_out = b;
            rtr = 1'b0;
            do tick(); while (!get && cyc < lim);
            repeat ($urandom_range(0, 2)) tick();
            get_ack = 1'b1;
            rtr = 1'b1;
            do tick(); while (get && cyc < lim);
            get_ack = 1'b0;
        end
    endtask

    // Random consumer on the rx valid/ready port.
    task automatic consumer(input int lim);
        logic [7:0] e;
        while (rx_got < NBYTES && cyc < lim) begin
            tick();
            rx_ready = 1'($urandom_range(0, 1));
            if (rx_valid && rx_ready) begin
                if (rx_exp.size() == 0) begin
                    chk("rx_extra", 32'(rx_data), 32'hFFFF_FFFF);
                end else begin
                    e = rx_exp.pop_front();
                    chk("rx_byte", 32'(rx_data), 32'(e));
                end
                rx_got++;
            end
        end
        rx_ready = 1'b0;
    endtask

    initial begin
        int lim;
        arb_vec_t v;

        tbl[0]  = '{4'b1111, 4'b0001, 8'hA0, 0};
        tbl[1]  = '{4'b1111, 4'b0010, 8'hB1, 1};
        tbl[2]  = '{4'b1111, 4'b0100, 8'hC2, 2};
        tbl[3]  = '{4'b1111, 4'b1000, 8'hD3, 0};
        tbl[4]  = '{4'b1111, 4'b0001, 8'hA0, 1};
        tbl[5]  = '{4'b1111, 4'b0010, 8'hB1, 0};
        tbl[6]  = '{4'b1001, 4'b1000, 8'hD3, 2};
        tbl[7]  = '{4'b1001, 4'b0001, 8'hA0, 0};
        tbl[8]  = '{4'b0100, 4'b0100, 8'hC2, 1};
        tbl[9]  = '{4'b0011, 4'b0001, 8'hA0, 0};
        tbl[10] = '{4'b0011, 4'b0010, 8'hB1, 2};
        tbl[11] = '{4'b0010, 4'b0010, 8'hB1, 0};

        reset = 1'b1;
        rts = 1'b0;
        rtr = 1'b1;
        byte_out = 8'h00;
        get_ack = 1'b0;
        put_ack = 1'b0;
        tx_req = '0;
        tx_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        rx_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        chk("rst_put", 32'(put), 32'd0);
        chk("rst_get", 32'(get), 32'd0);
        chk("rst_byte_in", 32'(byte_in), 32'd0);
        chk("rst_grant", 32'(tx_grant), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);

        // Round-robin table, starting from client 0 after reset
        for (int k = 0; k < 12; k++) tx_xfer(tbl[k]);

        // Single client 1 with byte A5, ack after 2 cycles
        tx_data[15:8] = 8'hA5;
        v = '{4'b0010, 4'b0010, 8'hA5, 2};
        tx_xfer(v);
        tx_data[15:8] = 8'hB1;

        // rts held high blocks client 2; release gives a grant on the next edge
        rts = 1'b1;
        tx_req = 4'b0100;
        repeat (4) begin
            tick();
            chk("rts_no_grant", 32'(tx_grant), 32'd0);
            chk("rts_no_put", 32'(put), 32'd0);
        end
        rts = 1'b0;
        tick();
        chk("rts_grant", 32'(tx_grant), 32'b0100);
        chk("rts_put", 32'(put), 32'd1);
        chk("rts_byte", 32'(byte_in), 32'hC2);
        tx_req = '0;
        put_ack = 1'b1;
        tick();
        put_ack = 1'b0;
        tick();

        // RX: first byte captured while consumer stalls, second waits for rx_ready
        byte_out = 8'h3C;
        rtr = 1'b0;
        tick();
        chk("rx1_valid", 32'(rx_valid), 32'd1);
        chk("rx1_data", 32'(rx_data), 32'h3C);
        chk("rx1_get", 32'(get), 32'd1);
        get_ack = 1'b1;
        rtr = 1'b1;
        tick();
        chk("rx1_get_fall", 32'(get), 32'd0);
        get_ack = 1'b0;
        tick();
        byte_out = 8'h7E;
        rtr = 1'b0;
        repeat (3) begin
            tick();
            chk("rx2_no_get", 32'(get), 32'd0);
            chk("rx2_hold_data", 32'(rx_data), 32'h3C);
            chk("rx2_hold_valid", 32'(rx_valid), 32'd1);
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx2_data", 32'(rx_data), 32'h7E);
        chk("rx2_valid", 32'(rx_valid), 32'd1);
        chk("rx2_get", 32'(get), 32'd1);
        get_ack = 1'b1;
        rtr = 1'b1;
        tick();
        get_ack = 1'b0;
        tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx2_consumed", 32'(rx_valid), 32'd0);

        // Reset in T_PUT with put_ack high; stale ack must not start a transfer
        tx_req = 4'b1000;
        tick();
        chk("rstmid_put", 32'(put), 32'd1);
        chk("rstmid_grant", 32'(tx_grant), 32'b1000);
        tx_req = '0;
        put_ack = 1'b1;
        reset = 1'b1;
        tick();
        chk("rstmid_put_drop", 32'(put), 32'd0);
        reset = 1'b0;
        tx_req = 4'b1111;
        repeat (3) begin
            tick();
            chk("rstmid_stale_put", 32'(put), 32'd0);
            chk("rstmid_stale_grant", 32'(tx_grant), 32'd0);
        end
        put_ack = 1'b0;
        tick();
        chk("rstmid_regrant", 32'(tx_grant), 32'b0001);
        chk("rstmid_reput", 32'(put), 32'd1);
        chk("rstmid_byte", 32'(byte_in), 32'hA0);
        tx_req = '0;
        put_ack = 1'b1;
        tick();
        put_ack = 1'b0;
        tick();

        // Concurrent random traffic in both directions
        lim = cyc + 40000;
        fork
            clients(lim);
            uart_tx(lim);
            pc_rx(lim);
            consumer(lim);
        join
        chk("tx_count", 32'(tx_got), 32'(NBYTES));
        chk("rx_count", 32'(rx_got), 32'(NBYTES));
        chk("tx_leftover", 32'(tx_exp.size()), 32'd0);
        chk("rx_leftover", 32'(rx_exp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
